// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and counter-width helper for serial_sub
package serial_sub_pkg;
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t SHIFT = 2'd1;
   localparam state_t DONE  = 2'd2;
   function automatic int cnt_w(int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle for serial_sub; SERIAL_SUB_OVF_EN adds ovf
interface serial_sub_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_sub_fs_cell.sv
// fs_cell: one-bit full subtractor, {bo, d} = x - y - bi
module fs_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign {bo, d} = {1'b0, x} - {1'b0, y} - {1'b0, bi};
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, LSB first; SERIAL_SUB_OVF_EN adds signed overflow output
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        rst,
   serial_sub_if.slave s
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa, sb, res, res_nx, diff_q;
   logic             br, bout_q, d, bo, last;
   fs_cell u_cell (.x(sa[0]), .y(sb[0]), .bi(br), .d(d), .bo(bo));
   // difference bits enter at the MSB so the result ends up LSB-aligned
   assign res_nx = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
   assign last   = cnt == CW'(WIDTH - 1);
`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk)
      if (rst) ovf_q <= 1'b0;
      else if (state == IDLE && s.start) ovf_q <= 1'b0;
      else if (state == SHIFT && last) ovf_q <= br ^ bo;
   assign s.ovf = ovf_q;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sa     <= '0;
         sb     <= '0;
         br     <= 1'b0;
         res    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (state == IDLE) begin
         if (s.start) begin
            state  <= SHIFT;
            cnt    <= '0;
            sa     <= s.a;
            sb     <= s.b;
            br     <= s.bin;
            res    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
         end
      end else if (state == SHIFT) begin
         res <= res_nx;
         br  <= bo;
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         cnt <= cnt + 1'b1;
         if (last) begin
            state  <= DONE;
            diff_q <= res_nx;
            bout_q <= bo;
         end
      end else begin
         state <= IDLE;
      end
   end
   assign s.busy = state == SHIFT;
   assign s.done = state == DONE;
   assign s.diff = diff_q;
   assign s.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed self-checking bench for serial_sub at WIDTH=8
module tb_serial_sub;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   serial_sub_if #(.WIDTH(8)) bus ();
   serial_sub #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus.slave));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic do_op(string tag, logic [7:0] a, logic [7:0] b, logic bin,
                        logic [7:0] ed, logic eb, logic eo);
      int n;
      bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.bin = ~bin;
      chk({tag, "_busy"}, bus.busy, 1);
      chk({tag, "_clr"}, {bus.diff, bus.bout}, 0);
      n = 0;
      while (!bus.done && n < 30) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_diff"}, bus.diff, ed);
      chk({tag, "_bout"}, bus.bout, eb);
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, bus.ovf, eo);
`else
      if (eo === 1'bx) chk({tag, "_eo"}, eo, 0);
`endif
      chk({tag, "_busy0"}, bus.busy, 0);
      step();
      chk({tag, "_pulse"}, bus.done, 0);
      chk({tag, "_hold"}, {bus.diff, bus.bout}, {ed, eb});
   endtask
   initial begin
      int n, nd, nb;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
      repeat (3) step();
      chk("rst_state", {bus.busy, bus.done, bus.diff, bus.bout}, 0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", bus.ovf, 0);
`endif
      rst = 1'b0;
      step();
      chk("idle", {bus.busy, bus.done}, 0);
      do_op("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      do_op("t2", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      do_op("t3", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      do_op("t4", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      do_op("t5", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
      do_op("t6", 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);
      // a second start mid-operation must be ignored
      bus.a = 8'h10; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      nd = 0; nb = 1;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) begin bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1; end
         if (i == 3) bus.start = 1'b0;
         step();
         if (bus.busy) nb++;
         if (bus.done) begin
            nd++;
            chk("ign_diff", bus.diff, 8'h0F);
         end
      end
      chk("ign_done_cnt", nd, 1);
      chk("ign_busy_cnt", nb, 8);
      // start held through DONE is accepted in the following idle cycle
      bus.a = 8'h03; bus.b = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
      step();
      n = 0;
      while (!bus.done && n < 30) begin step(); n++; end
      chk("held_lat", n, 8);
      step();
      chk("held_idle", bus.busy, 0);
      step();
      bus.start = 1'b0;
      chk("held_reaccept", bus.busy, 1);
      repeat (12) step();
      chk("held_diff", bus.diff, 8'h02);
      // reset mid-operation discards the partial result
      do_op("pre", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      bus.a = 8'h44; bus.b = 8'h11; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst", {bus.busy, bus.done, bus.diff, bus.bout}, 0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done || bus.busy) nd++;
      end
      chk("mid_rst_quiet", nd, 0);
      // reset wins over start on the same edge
      rst = 1'b1; bus.start = 1'b1;
      step();
      rst = 1'b0; bus.start = 1'b0;
      chk("rst_prio", bus.busy, 0);
      do_op("post", 8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
